dm_responder: RTL and testbench

- Memory-side responder for the core's data-memory port.
- Accepts load/store requests with a valid/ready handshake and holds the request for a configurable wait-state count.
- Performs byte/half/word access on a 1K x 32 array and returns read data, extended per MemEXT, through a valid/ready response channel.
- Sits between the core's load/store path and on-chip data storage. It replaces the zero-latency DataMem when stall-capable memory is needed.

---
 rtl/dm_responder_pkg.sv | 31 +++
 rtl/dm_array.sv | 26 ++
 rtl/dm_responder.sv | 138 +++++++++++++
 tb/tb_dm_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder: MemOp/MemEXT codes,
// FSM states and the request-legality check.
package dm_responder_pkg;

  localparam logic [1:0] MEMOP_WORD = 2'b00;
  localparam logic [1:0] MEMOP_HALF = 2'b01;
  localparam logic [1:0] MEMOP_BYTE = 2'b10;
  localparam logic [1:0] MEMOP_RSVD = 2'b11;

  localparam logic MEMEXT_ZERO = 1'b0;
  localparam logic MEMEXT_SIGN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the access cannot be performed: misaligned or reserved op.
  function automatic logic req_bad(input logic [1:0] op, input logic [1:0] lo);
    logic bad;
    case (op)
      MEMOP_WORD: bad = (lo != 2'b00);
      MEMOP_HALF: bad = lo[0];
      MEMOP_BYTE: bad = 1'b0;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised storage with per-byte write enables and combinational read.
// Contents are deliberately not reset.
module dm_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dm_responder.sv
// Stall-capable data-memory responder: captures one request, waits LATENCY
// cycles, performs the byte/half/word access and holds the response until taken.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_op,
  input  logic          req_ext,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [1:0]    dbg_state
);

  state_t state, state_nx;
  logic [3:0] cnt;
  logic accept, access;

  logic          q_we, q_ext;
  logic [1:0]    q_op;
  logic [AW+1:0] q_addr;
  logic [31:0]   q_wdata;

  logic        bad, arr_we, sx;
  logic [3:0]  arr_be;
  logic [31:0] arr_wdata, arr_rdata, load_data;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // req_ready is high only in IDLE, and the response is held unchanged in
  // RESP until rsp_ready is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        accept   = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: if (cnt == 4'd0) begin
        access   = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign dbg_state = state;

  // Store lanes: replicate the low bits so any enabled lane sees the right byte.
  always_comb begin
    bad       = req_bad(q_op, q_addr[1:0]);
    arr_be    = 4'b0000;
    arr_wdata = q_wdata;
    case (q_op)
      MEMOP_WORD: arr_be = 4'b1111;
      MEMOP_HALF: begin
        arr_be    = q_addr[1] ? 4'b1100 : 4'b0011;
        arr_wdata = {2{q_wdata[15:0]}};
      end
      MEMOP_BYTE: begin
        arr_be    = 4'b0001 << q_addr[1:0];
        arr_wdata = {4{q_wdata[7:0]}};
      end
      default: arr_be = 4'b0000;
    endcase
    arr_we = access && q_we && !bad;
  end

  always_comb begin
    sx     = (q_ext == MEMEXT_SIGN);
    lane_h = 16'(arr_rdata >> {q_addr[1], 4'b0000});
    lane_b = 8'(arr_rdata >> {q_addr[1:0], 3'b000});
    case (q_op)
      MEMOP_HALF: load_data = {{16{sx & lane_h[15]}}, lane_h};
      MEMOP_BYTE: load_data = {{24{sx & lane_b[7]}}, lane_b};
      default:    load_data = arr_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      q_we      <= 1'b0;
      q_op      <= MEMOP_WORD;
      q_ext     <= MEMEXT_ZERO;
      q_addr    <= '0;
      q_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        q_we    <= req_we;
        q_op    <= req_op;
        q_ext   <= req_ext;
        q_addr  <= req_addr;
        q_wdata <= req_wdata;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_err   <= bad;
        rsp_rdata <= (bad || q_we) ? 32'd0 : load_data;
      end
    end
  end

  dm_array #(.AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .index (q_addr[AW+1:2]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: word-level memory model plus timing expectations,
// directed literal cases from the test plan and a randomized phase.
module tb_dm_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_op = 2'b00;
  logic          req_ext = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  dm_responder #(.AW(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_ext   (req_ext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic          we;
    logic [1:0]    op;
    logic          ext;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    int            due;
  } req_t;

  req_t        pend_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] mdl [2**AW];

  int n_checks = 0;
  int n_fail   = 0;
  int neg_cyc  = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply the access to a plain word array, return {err, rdata}.
  function automatic logic [32:0] model_exec(input req_t r);
    int w, k;
    logic err;
    logic [31:0] word, rd;
    logic [15:0] h;
    logic [7:0]  b;
    w    = int'(r.addr[AW+1:2]);
    k    = int'(r.addr[1:0]);
    err  = (r.op == 2'b11) || (r.op == 2'b00 && k != 0) || (r.op == 2'b01 && (k % 2) != 0);
    word = mdl[w];
    rd   = 32'd0;
    h    = 16'(word >> (8 * k));
    b    = 8'(word >> (8 * k));
    if (!err && r.we) begin
      case (r.op)
        2'b00:   mdl[w] = r.wdata;
        2'b01:   mdl[w] = (word & ~(32'hFFFF << (8 * k))) | ({16'd0, r.wdata[15:0]} << (8 * k));
        default: mdl[w] = (word & ~(32'hFF << (8 * k))) | ({24'd0, r.wdata[7:0]} << (8 * k));
      endcase
    end else if (!err) begin
      case (r.op)
        2'b00:   rd = word;
        2'b01:   rd = r.ext ? {{16{h[15]}}, h} : {16'd0, h};
        default: rd = r.ext ? {{24{b[7]}}, b} : {24'd0, b};
      endcase
    end
    return {err, rd};
  endfunction

  // Single compare process, evaluated mid-cycle.
  always @(negedge clk) begin
    neg_cyc++;
    if (!rst) begin
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      pend_q.delete();
      exp_q.delete();
    end else begin
      chk("req_ready", 32'(req_ready), 32'(pend_q.size() == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(pend_q.size() != 0 && neg_cyc >= pend_q[0].due));
      if (pend_q.size() != 0 && neg_cyc >= pend_q[0].due && exp_q.size() == 0)
        exp_q.push_back(model_exec(pend_q[0]));
      if (rsp_valid && exp_q.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0][32]));
        if (rsp_ready) begin
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          void'(pend_q.pop_front());
          void'(exp_q.pop_front());
          done_cnt++;
        end
      end
      if (req_valid && req_ready)
        pend_q.push_back('{we: req_we, op: req_op, ext: req_ext, addr: req_addr,
                           wdata: req_wdata, due: neg_cyc + LAT + 1});
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic junk(input logic with_valid);
    req_we    = 1'($urandom);
    req_op    = 2'($urandom);
    req_ext   = 1'($urandom);
    req_addr  = (AW + 2)'($urandom);
    req_wdata = $urandom;
    req_valid = with_valid ? 1'($urandom) : 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic issue(input logic we, input logic [1:0] op, input logic ext,
                       input logic [AW+1:0] addr, input logic [31:0] wdata);
    int g = 0;
    while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
    chk("issue req_ready", 32'(req_ready), 32'd1);
    req_we = we; req_op = op; req_ext = ext; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    junk(1'b0);
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int g = 0;
    while (done_cnt == start && g < 100) begin
      junk(1'b1);
      @(posedge clk); #1;
      g++;
    end
    req_valid = 1'b0;
    chk("response timeout", 32'(done_cnt != start), 32'd1);
  endtask

  task automatic xact(input logic we, input logic [1:0] op, input logic ext,
                      input logic [AW+1:0] addr, input logic [31:0] wdata);
    int c = 0;
    issue(we, op, ext, addr, wdata);
    while (!rsp_valid && c < 20) begin @(posedge clk); #1; c++; end
    chk("latency", 32'(c), 32'(LAT));
    wait_done();
  endtask

  task automatic expect_last(input string name, input logic [31:0] rd, input logic err);
    chk({name, " rdata"}, last_rdata, rd);
    chk({name, " err"}, 32'(last_err), 32'(err));
  endtask

  initial begin
    int c;
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 32; i++) xact(1'b1, 2'b00, 1'b0, 12'(i * 4), $urandom);

    xact(1'b1, 2'b00, 1'b0, 12'h010, 32'hDEADBEEF);
    expect_last("word store", 32'd0, 1'b0);
    xact(1'b0, 2'b00, 1'b0, 12'h010, 32'd0);
    expect_last("word load", 32'hDEADBEEF, 1'b0);

    xact(1'b1, 2'b00, 1'b0, 12'h020, 32'h80F17F82);
    xact(1'b0, 2'b10, 1'b1, 12'h020, 32'd0);
    expect_last("byte sext", 32'hFFFFFF82, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 12'h020, 32'd0);
    expect_last("byte zext", 32'h00000082, 1'b0);
    xact(1'b0, 2'b01, 1'b1, 12'h022, 32'd0);
    expect_last("half sext", 32'hFFFF80F1, 1'b0);

    xact(1'b1, 2'b00, 1'b0, 12'h020, 32'h11223344);
    xact(1'b1, 2'b10, 1'b0, 12'h021, 32'hFFFFFFAA);
    xact(1'b0, 2'b00, 1'b0, 12'h020, 32'd0);
    expect_last("byte store", 32'h1122AA44, 1'b0);
    xact(1'b1, 2'b01, 1'b0, 12'h022, 32'h1234BEEF);
    xact(1'b0, 2'b00, 1'b0, 12'h020, 32'd0);
    expect_last("half store", 32'hBEEFAA44, 1'b0);

    xact(1'b0, 2'b00, 1'b0, 12'h006, 32'd0);
    expect_last("misaligned word", 32'd0, 1'b1);
    xact(1'b1, 2'b00, 1'b0, 12'h030, 32'h55667788);
    xact(1'b1, 2'b01, 1'b0, 12'h031, 32'hAAAABBBB);
    expect_last("misaligned half store", 32'd0, 1'b1);
    xact(1'b0, 2'b00, 1'b0, 12'h030, 32'd0);
    expect_last("after bad store", 32'h55667788, 1'b0);
    xact(1'b0, 2'b11, 1'b1, 12'h000, 32'd0);
    expect_last("reserved op", 32'd0, 1'b1);

    rdy_mode = 2;
    @(posedge clk); #1;
    issue(1'b0, 2'b00, 1'b0, 12'h010, 32'd0);
    c = 0;
    while (!rsp_valid && c < 20) begin @(posedge clk); #1; c++; end
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp req_ready", 32'(req_ready), 32'd0);
    end
    rdy_mode = 0;
    wait_done();
    xact(1'b0, 2'b00, 1'b0, 12'h020, 32'd0);
    expect_last("after backpressure", 32'hBEEFAA44, 1'b0);

    xact(1'b1, 2'b00, 1'b0, 12'h040, 32'hCAFEF00D);
    xact(1'b0, 2'b00, 1'b0, 12'h040, 32'd0);
    issue(1'b1, 2'b00, 1'b0, 12'h040, 32'h12345678);
    #2 rst = 1'b0;
    #1;
    chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async rst req_ready", 32'(req_ready), 32'd1);
    chk("async rst rsp_rdata", rsp_rdata, 32'd0);
    chk("async rst state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    xact(1'b0, 2'b00, 1'b0, 12'h040, 32'd0);
    expect_last("dropped store", 32'hCAFEF00D, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rdy_mode = $urandom_range(0, 1);
      xact(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           12'($urandom_range(0, 127)), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
